// File: rtl/apb_mst_pkg.sv
// apb_mst_pkg: shared FSM state encoding and watchdog counter width for apb_cmd_master.
package apb_mst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response streams plus the APB3 bus of apb_cmd_master.
// Handshake: a beat transfers on a rising pclk edge where valid and ready are both high;
// the producer holds valid and its payload stable until that edge, ready may change freely.
interface apb_cmd_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [2:0]    req_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_prot, rsp_ready,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pprot
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_prot, rsp_ready,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pprot
  );
endinterface

// File: rtl/apb_mst_tmo_cnt.sv
// apb_mst_tmo_cnt: ACCESS-phase wait counter; expired_o flags the cycle whose
// increment would reach the limit, so the master leaves ACCESS after `limit` cycles.
module apb_mst_tmo_cnt
  import apb_mst_pkg::*;
#(
  parameter int CW = TMO_CNT_W
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic [CW-1:0] limit_i,
  output logic          expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;

  always_comb begin
    cnt_inc   = {1'b0, cnt_q} + (CW+1)'(1);
    expired_o = enable_i && (cnt_inc >= {1'b0, limit_i});
    cnt_d     = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_inc[CW-1:0];
  end

  always_ff @(posedge pclk) begin
    if (preset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: one-at-a-time APB3 initiator driven by a valid/ready command stream.
// Define APB_CMD_MASTER_TIMEOUT_EN to add the hung-slave watchdog (apb_mst_tmo_cnt).
module apb_cmd_master
  import apb_mst_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             pclk,
  input  logic             preset,
  apb_cmd_master_if.master bus,
  output state_e           state_dbg_o
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT must be within 1..65535");
  end

  state_e        state_q, state_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [2:0]    pprot_q, pprot_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT);
  logic tmo_expired;
  logic rsp_tmo_q, rsp_tmo_d;

  apb_mst_tmo_cnt #(.CW(TMO_CNT_W)) u_tmo_cnt (
    .pclk      (pclk),
    .preset    (preset),
    .clear_i   (state_q == ST_SETUP),
    .enable_i  ((state_q == ST_ACCESS) && !bus.pready),
    .limit_i   (TMO_LIMIT),
    .expired_o (tmo_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pprot_d     = pprot_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    rsp_tmo_d   = rsp_tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d  = ST_SETUP;
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          pwdata_d = bus.req_wdata;
          pprot_d  = bus.req_prot;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // pready takes priority over a watchdog expiry in the same cycle
        if (bus.pready) begin
          state_d     = ST_RESP;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          rsp_tmo_d   = 1'b0;
        end else if (tmo_expired) begin
          state_d     = ST_RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
`endif
        end
      end
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Bus controls are registered from the next state so they align with it.
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      rsp_tmo_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      rsp_tmo_q   <= rsp_tmo_d;
`endif
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_tmo_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table-driven transfers plus hand-written backpressure, reset and
// watchdog sequences; responses are checked against an expected queue.
module tb_apb_cmd_master;
  import apb_mst_pkg::*;

  localparam int W = 34;  // {rsp_err, rsp_timeout, rsp_rdata}

  logic   pclk;
  logic   preset;
  state_e state_dbg;

  apb_cmd_master_if #(.AW(32), .DW(32)) bus ();

  apb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .bus         (bus.master),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "global time limit");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: pop on every response handshake
  always begin
    @(negedge pclk);
    #1;
    if (!preset && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected: got rsp 0x%0h, expected no response",
                 {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rsp_payload", 64'({bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}), 64'(e));
      end
    end
  end

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] prot);
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_prot  = prot;
  endtask

  // One transfer: n_acc ACCESS cycles, pready in the last one when rdy_last is set.
  task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] prot, input int n_acc,
                          input logic rdy_last, input logic [31:0] rdata, input logic slverr,
                          input logic [W-1:0] exp_rsp);
    @(negedge pclk);
    check({tag, " req_ready_idle"}, 64'(bus.req_ready), 64'(1));
    drive_req(wr, addr, wdata, prot);
    bus.req_valid = 1'b1;
    exp_q.push_back(exp_rsp);
    @(negedge pclk);  // T+1: SETUP
    bus.req_valid = 1'b0;
    drive_req(~wr, $urandom(), $urandom(), 3'($urandom_range(0, 7)));
    check({tag, " setup_psel"},    64'(bus.psel), 64'(1));
    check({tag, " setup_penable"}, 64'(bus.penable), 64'(0));
    check({tag, " setup_paddr"},   64'(bus.paddr), 64'(addr));
    check({tag, " setup_pwrite"},  64'(bus.pwrite), 64'(wr));
    check({tag, " setup_pwdata"},  64'(bus.pwdata), 64'(wdata));
    check({tag, " setup_pprot"},   64'(bus.pprot), 64'(prot));
    check({tag, " setup_req_ready"}, 64'(bus.req_ready), 64'(0));
    for (int i = 0; i < n_acc; i++) begin
      logic last;
      @(negedge pclk);
      last = (i == n_acc - 1);
      check({tag, " access_psel"},    64'(bus.psel), 64'(1));
      check({tag, " access_penable"}, 64'(bus.penable), 64'(1));
      check({tag, " access_paddr"},   64'(bus.paddr), 64'(addr));
      check({tag, " access_pwdata"},  64'(bus.pwdata), 64'(wdata));
      check({tag, " access_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
      bus.pready  = last && rdy_last;
      bus.prdata  = last ? rdata : $urandom();
      bus.pslverr = last ? slverr : 1'b1;
    end
    @(negedge pclk);  // RESP
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = $urandom();
    check({tag, " resp_rsp_valid"}, 64'(bus.rsp_valid), 64'(1));
    check({tag, " resp_psel"},      64'(bus.psel), 64'(0));
    check({tag, " resp_penable"},   64'(bus.penable), 64'(0));
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] rnd_rd;
    logic [31:0] rnd_addr;
    rnd_rd   = $urandom();
    rnd_addr = $urandom();
    vecs[0] = '{1'b1, 32'h4001_1000, 32'hA5A5_0001, 3'b010, 0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h4001_1004, 32'h0, 3'b000, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h4001_2000, 32'h0, 3'b001, 1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1};
    vecs[3] = '{1'b1, 32'h4001_2004, 32'h7777_0000, 3'b100, 2, 32'h1111_2222, 1'b1, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 32'h4002_0010, 32'h0, 3'b111, 0, rnd_rd, 1'b0, rnd_rd, 1'b0};
    vecs[5] = '{1'b1, rnd_addr, 32'h0F0F_F0F0, 3'b011, 1, 32'h3333_4444, 1'b0, 32'h0, 1'b0};

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    drive_req(1'b0, '0, '0, '0);

    // reset values
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst psel",        64'(bus.psel), 64'(0));
    check("rst penable",     64'(bus.penable), 64'(0));
    check("rst pwrite",      64'(bus.pwrite), 64'(0));
    check("rst paddr",       64'(bus.paddr), 64'(0));
    check("rst pwdata",      64'(bus.pwdata), 64'(0));
    check("rst pprot",       64'(bus.pprot), 64'(0));
    check("rst rsp_valid",   64'(bus.rsp_valid), 64'(0));
    check("rst rsp_rdata",   64'(bus.rsp_rdata), 64'(0));
    check("rst rsp_err",     64'(bus.rsp_err), 64'(0));
    check("rst rsp_timeout", 64'(bus.rsp_timeout), 64'(0));
    preset = 1'b0;
    @(negedge pclk);
    check("post_rst req_ready", 64'(bus.req_ready), 64'(1));
    check("post_rst state",     64'(state_dbg), 64'(ST_IDLE));

    // table-driven transfers
    foreach (vecs[k]) begin
      run_xfer($sformatf("vec%0d", k), vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].prot,
               vecs[k].waits + 1, 1'b1, vecs[k].rdata, vecs[k].slverr,
               {vecs[k].exp_err, 1'b0, vecs[k].exp_rdata});
    end
    @(negedge pclk);
    check("idle paddr_hold",  64'(bus.paddr), 64'(rnd_addr));
    check("idle pwdata_hold", 64'(bus.pwdata), 64'(32'h0F0F_F0F0));
    check("idle psel",        64'(bus.psel), 64'(0));

    // response backpressure with the next command held valid
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 32'h4000_0100, 32'h0, 3'b001);
    bus.req_valid = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h5555_AAAA});
    @(negedge pclk);
    drive_req(1'b1, 32'h4000_0200, 32'h0BAD_CAFE, 3'b100);
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    check("bp setup_psel", 64'(bus.psel), 64'(1));
    @(negedge pclk);
    bus.pready = 1'b1;
    bus.prdata = 32'h5555_AAAA;
    @(negedge pclk);
    bus.pready = 1'b0;
    bus.prdata = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("bp rsp_rdata", 64'(bus.rsp_rdata), 64'(32'h5555_AAAA));
      check("bp req_ready", 64'(bus.req_ready), 64'(0));
      check("bp psel",      64'(bus.psel), 64'(0));
      @(negedge pclk);
    end
    bus.rsp_ready = 1'b1;
    check("bp rsp_valid_at_hs", 64'(bus.rsp_valid), 64'(1));
    @(negedge pclk);
    check("bp after_hs psel",      64'(bus.psel), 64'(0));
    check("bp after_hs req_ready", 64'(bus.req_ready), 64'(1));
    @(negedge pclk);
    bus.req_valid = 1'b0;
    check("bp next_setup psel",    64'(bus.psel), 64'(1));
    check("bp next_setup penable", 64'(bus.penable), 64'(0));
    check("bp next_setup paddr",   64'(bus.paddr), 64'(32'h4000_0200));
    check("bp next_setup pwrite",  64'(bus.pwrite), 64'(1));
    @(negedge pclk);
    bus.pready = 1'b1;
    @(negedge pclk);
    bus.pready = 1'b0;
    check("bp second rsp_valid", 64'(bus.rsp_valid), 64'(1));

    // reset in the 2nd ACCESS wait cycle discards the transfer
    @(negedge pclk);
    drive_req(1'b0, 32'h4003_0000, 32'h0, 3'b000);
    bus.req_valid = 1'b1;
    @(negedge pclk);
    bus.req_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("rma access penable", 64'(bus.penable), 64'(1));
    preset = 1'b1;
    @(negedge pclk);
    check("rma psel",      64'(bus.psel), 64'(0));
    check("rma penable",   64'(bus.penable), 64'(0));
    check("rma rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rma state",     64'(state_dbg), 64'(ST_IDLE));
    preset = 1'b0;
    @(negedge pclk);
    check("rma req_ready", 64'(bus.req_ready), 64'(1));
    check("rma paddr",     64'(bus.paddr), 64'(0));
    run_xfer("after_rst", 1'b0, 32'h4003_0004, 32'h0, 3'b010, 2, 1'b1, 32'h0000_BEEF, 1'b0,
             {1'b0, 1'b0, 32'h0000_BEEF});

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    run_xfer("tmo_abort", 1'b0, 32'h4004_0000, 32'h0, 3'b000, 4, 1'b0, 32'h9999_9999, 1'b0,
             {1'b1, 1'b1, 32'h0});
    run_xfer("tmo_edge", 1'b0, 32'h4004_0004, 32'h0, 3'b000, 4, 1'b1, 32'h6666_1234, 1'b0,
             {1'b0, 1'b0, 32'h6666_1234});
`endif

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge pclk);
    @(negedge pclk);
    check("scoreboard drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
